// File: rtl/rank_scatter_buf.sv
// rank_scatter_buf: scatters ranked results into slot score-1, then drains the sorted window over valid/ready
module rank_scatter_buf #(
    parameter int DATA_W  = 20,
    parameter int N       = 16,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rank_valid_i,
    input  logic [SCORE_W-1:0] rank_score_i,
    input  logic [DATA_W-1:0]  rank_data_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               sort_valid_o,
    input  logic               sort_ready_i,
    output logic [DATA_W-1:0]  sort_data_o,
    output logic [SCORE_W-1:0] sort_idx_o,
    output logic               sort_last_o,
    output logic               done_o,
    output logic [2:0]         err_o
);
    localparam int SLOT_W = $clog2(N);
    localparam int CNT_W  = $clog2(N + 1);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [N];
    logic [N-1:0]        written;
    logic [CNT_W-1:0]    cnt;
    logic [SLOT_W-1:0]   rd_ptr, nxt_ptr, slot;
    logic [SCORE_W-1:0]  score_m1;
    logic                in_range, we;
    logic [DATA_W-1:0]   nxt_data, beat0;

    assign score_m1 = rank_score_i - SCORE_W'(1);
    assign slot     = score_m1[SLOT_W-1:0];
    assign in_range = (rank_score_i != '0) && (rank_score_i <= SCORE_W'(N));
    assign we       = (state == COLLECT) && rank_valid_i && !flush_i && in_range && !written[slot];
    assign nxt_ptr  = rd_ptr + SLOT_W'(1);
    assign nxt_data = written[nxt_ptr] ? mem[nxt_ptr] : '0;
    // The Nth strobe may itself fill slot 0, so beat 0 bypasses the array
    assign beat0    = (we && slot == '0) ? rank_data_i : (written[0] ? mem[0] : '0);

    always_ff @(posedge clk) begin
        if (we) mem[slot] <= rank_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= COLLECT;
            written      <= '0;
            cnt          <= '0;
            rd_ptr       <= '0;
            busy_o       <= 1'b0;
            sort_valid_o <= 1'b0;
            sort_data_o  <= '0;
            sort_idx_o   <= '0;
            sort_last_o  <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= '0;
        end else if (flush_i) begin
            state        <= COLLECT;
            written      <= '0;
            cnt          <= '0;
            rd_ptr       <= '0;
            busy_o       <= 1'b0;
            sort_valid_o <= 1'b0;
            sort_data_o  <= '0;
            sort_idx_o   <= '0;
            sort_last_o  <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= '0;
        end else begin
            done_o <= 1'b0;
            if (state == COLLECT) begin
                if (rank_valid_i) begin
                    cnt <= cnt + CNT_W'(1);
                    if (!in_range) err_o[0] <= 1'b1;
                    else if (written[slot]) err_o[1] <= 1'b1;
                    else written[slot] <= 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        state        <= DRAIN;
                        busy_o       <= 1'b1;
                        sort_valid_o <= 1'b1;
                        sort_data_o  <= beat0;
                        sort_idx_o   <= '0;
                        sort_last_o  <= (N == 1);
                        rd_ptr       <= '0;
                    end
                end
            end else begin
                if (rank_valid_i) err_o[2] <= 1'b1;
                if (sort_ready_i) begin
                    if (sort_last_o) begin
                        state        <= COLLECT;
                        busy_o       <= 1'b0;
                        sort_valid_o <= 1'b0;
                        sort_data_o  <= '0;
                        sort_idx_o   <= '0;
                        sort_last_o  <= 1'b0;
                        done_o       <= 1'b1;
                        cnt          <= '0;
                        written      <= '0;
                        rd_ptr       <= '0;
                    end else begin
                        rd_ptr      <= nxt_ptr;
                        sort_data_o <= nxt_data;
                        sort_idx_o  <= SCORE_W'(nxt_ptr);
                        sort_last_o <= (nxt_ptr == SLOT_W'(N - 1));
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rank_scatter_buf.sv
// tb_rank_scatter_buf: table-driven windows with hand-computed sorted slots, plus flush and reset corner sequences
module tb_rank_scatter_buf;
    localparam int DW = 20;
    localparam int N  = 16;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rank_valid = 1'b0;
    logic [SW-1:0] rank_score = '0;
    logic [DW-1:0] rank_data = '0;
    logic          flush = 1'b0;
    logic          busy, sort_valid, sort_last, done;
    logic          sort_ready = 1'b0;
    logic [DW-1:0] sort_data;
    logic [SW-1:0] sort_idx;
    logic [2:0]    err;

    rank_scatter_buf #(.DATA_W(DW), .N(N), .SCORE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .rank_valid_i(rank_valid), .rank_score_i(rank_score),
        .rank_data_i(rank_data), .flush_i(flush), .busy_o(busy), .sort_valid_o(sort_valid),
        .sort_ready_i(sort_ready), .sort_data_o(sort_data), .sort_idx_o(sort_idx),
        .sort_last_o(sort_last), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] score;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tv [N];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe i carries tv[i].score/data; tv[k].exp is the expected datum of slot k
    task automatic fill(input int t);
        for (int s = 0; s < N; s++) begin
            case (t)
                3: begin
                    tv[s].score = (s < 2) ? SW'(3) : (s < 4) ? SW'(s - 1) : SW'(s);
                    tv[s].data  = (s == 0) ? DW'('hA) : (s == 1) ? DW'('hB) : DW'('h100 + 32'(tv[s].score));
                    tv[s].exp   = (s == 2) ? DW'('hA) : (s == 15) ? DW'(0) : DW'('h100 + s + 1);
                end
                4: begin
                    tv[s].score = (s == 0) ? SW'(0) : SW'(s + 1);
                    tv[s].data  = (s == 0) ? DW'('h77) : DW'('h200 + s + 1);
                    tv[s].exp   = (s == 0) ? DW'(0) : DW'('h200 + s + 1);
                end
                6: begin
                    tv[s].score = SW'(((s * 5) % N) + 1);
                    tv[s].data  = DW'('h300 + s * 3);
                end
                default: begin
                    tv[s].score = SW'(16 - s);
                    tv[s].data  = DW'('hF0 + s);
                    tv[s].exp   = DW'('hFF - s);
                end
            endcase
        end
        if (t == 6)
            for (int s = 0; s < N; s++) tv[32'(tv[s].score) - 1].exp = tv[s].data;
    endtask

    task automatic send(input int count);
        for (int s = 0; s < count; s++) begin
            chk("collect_idle", {30'b0, busy, sort_valid}, 0);
            rank_valid = 1'b1;
            rank_score = tv[s].score;
            rank_data  = tv[s].data;
            tick();
        end
        rank_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input int pulse_beat, input logic [2:0] exp_err);
        int            b = 0;
        int            cyc = 0;
        logic [DW-1:0] hd;
        logic [SW-1:0] hi;
        logic          hl;
        while (b < N && cyc < 200) begin
            sort_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            rank_valid = (b == pulse_beat) && sort_ready;
            rank_score = SW'(1);
            rank_data  = DW'('h55);
            chk("drain_valid", 32'(sort_valid), 1);
            chk("drain_busy", 32'(busy), 1);
            hd = sort_data;
            hi = sort_idx;
            hl = sort_last;
            if (sort_ready) begin
                chk("beat_data", 32'(sort_data), 32'(tv[b].exp));
                chk("beat_idx", 32'(sort_idx), b);
                chk("beat_last", 32'(sort_last), (b == N - 1) ? 1 : 0);
                b++;
            end
            tick();
            rank_valid = 1'b0;
            if (!sort_ready) begin
                chk("hold_data", 32'(sort_data), 32'(hd));
                chk("hold_idx", 32'(sort_idx), 32'(hi));
                chk("hold_last", 32'(sort_last), 32'(hl));
            end
            cyc++;
        end
        if (b < N) chk("drain_timeout", b, N);
        chk("done_pulse", 32'(done), 1);
        chk("end_valid", 32'(sort_valid), 0);
        chk("end_busy", 32'(busy), 0);
        chk("err", 32'(err), 32'(exp_err));
        tick();
        chk("done_once", 32'(done), 0);
    endtask

    task automatic do_flush(input bit with_strobe);
        flush      = 1'b1;
        rank_valid = with_strobe;
        rank_score = SW'(1);
        rank_data  = DW'('h999);
        tick();
        flush      = 1'b0;
        rank_valid = 1'b0;
        chk("flush_state", {25'b0, err, busy, sort_valid, done, sort_last}, 0);
    endtask

    initial begin
        tick();
        chk("reset_async", {err, busy, sort_valid, done, sort_last, sort_idx, sort_data}, 0);
        rst_n = 1'b1;
        tick();
        chk("reset_state", {err, busy, sort_valid, done, sort_last, sort_idx, sort_data}, 0);

        fill(1); send(N); drain(1'b0, -1, 3'b000);
        fill(2); send(N); drain(1'b1, -1, 3'b000);
        do_flush(1'b0); fill(3); send(N); drain(1'b0, -1, 3'b010);
        do_flush(1'b0); fill(4); send(N); drain(1'b0, -1, 3'b001);
        do_flush(1'b0); fill(5); send(N); drain(1'b0, 5, 3'b100);
        do_flush(1'b0); fill(1); send(7); do_flush(1'b1);
        fill(6); send(N); drain(1'b0, -1, 3'b000);

        fill(1); send(N);
        sort_ready = 1'b1;
        repeat (3) tick();
        chk("mid_drain_idx", 32'(sort_idx), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out", {err, busy, sort_valid, done, sort_last, sort_idx, sort_data}, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("no_done_after_rst", {busy, sort_valid, done}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
